led_matrix_pwm: RTL and testbench

Parametrised multiplexed LED-matrix driver with per-pixel PWM brightness. It succeeds the fixed 4x4 on/off scanner. It takes a ROWS x COLS framebuffer of BPP-bit intensities through a simple write port and scans one source line at a time, with a blanking gap between lines. The block sits between user logic (synth visualisation, status) and the tri-stated source pins and active-low sink pins of the board LED matrix.

---
 rtl/led_matrix_pkg.sv | 23 ++
 rtl/led_frame_buf.sv | 95 +++++++++
 rtl/led_matrix_pwm.sv | 147 ++++++++++++++
 tb/tb_led_matrix_pwm.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_matrix_pkg.sv
// Shared constants, scan-state type and pixel addressing for the LED matrix driver.
package led_matrix_pkg;

  localparam int unsigned DEF_ROWS     = 4;
  localparam int unsigned DEF_COLS     = 4;
  localparam int unsigned DEF_BPP      = 4;
  localparam int unsigned DEF_TICK_DIV = 32;
  localparam int unsigned DEF_BLANK    = 16;

  // Scan phase: dark gap between source lines, then the PWM-lit window.
  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_LIT   = 1'b1
  } scan_state_e;

  // Pixels are stored column-major: one source line holds ROWS adjacent pixels.
  function automatic int unsigned pix_idx(input int unsigned col,
                                          input int unsigned row,
                                          input int unsigned rows);
    return col * rows + row;
  endfunction

endpackage

// File: rtl/led_frame_buf.sv
// Framebuffer for the LED matrix: write port, optional back/front swap and the
// per-column read slice (ROWS pixels of BPP bits for the selected column).
// Build option LED_MATRIX_DOUBLE_BUF_EN: when defined, writes land in a back
// buffer that is copied to the displayed buffer on swap; otherwise writes go
// straight to the displayed pixels.
module led_frame_buf
  import led_matrix_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  parameter int BPP  = DEF_BPP,
  parameter int AW   = 4,
  parameter int COLW = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [BPP-1:0]       wr_data,
  input  logic                 commit,
  input  logic                 swap,
  input  logic [COLW-1:0]      rd_col,
  output logic [ROWS*BPP-1:0]  rd_pix,
  output logic                 swap_pending
);

  localparam int NPIX = ROWS * COLS;

  logic [BPP-1:0] front_reg [NPIX];

`ifdef LED_MATRIX_DOUBLE_BUF_EN
  logic [BPP-1:0] back_reg  [NPIX];
  logic [BPP-1:0] back_next [NPIX];
  logic           pending_reg;
  logic           pending_next;
  logic           do_swap;

  // Back buffer with this cycle's write merged in, so a write on the swap
  // cycle is carried into the copy. Out-of-range addresses match no pixel.
  for (genvar gi = 0; gi < NPIX; gi++) begin : g_wr
    assign back_next[gi] = (wr_en && wr_addr == AW'(gi)) ? wr_data : back_reg[gi];
  end

  assign do_swap = swap && pending_reg;
  // A commit arriving on the swap cycle re-arms for the following frame.
  assign pending_next = commit | (pending_reg & ~do_swap);

  // Buffer storage, swap copy and pending flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NPIX; i++) begin
        back_reg[i]  <= '0;
        front_reg[i] <= '0;
      end
      pending_reg <= 1'b0;
    end else begin
      back_reg <= back_next;
      if (do_swap) begin
        front_reg <= back_next;
      end
      pending_reg <= pending_next;
    end
  end

  assign swap_pending = pending_reg;
`else
  logic unused_swap_inputs;
  assign unused_swap_inputs = commit ^ swap;

  // Single buffer: writes update the displayed pixels directly.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NPIX; i++) begin
        front_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NPIX; i++) begin
        if (wr_en && wr_addr == AW'(i)) begin
          front_reg[i] <= wr_data;
        end
      end
    end
  end

  assign swap_pending = 1'b0;
`endif

  // Read slice: the ROWS pixels of the column currently being scanned.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_rd
    logic [AW-1:0] rd_idx;
    assign rd_idx = AW'(pix_idx(32'(rd_col), gi, ROWS));
    assign rd_pix[gi*BPP +: BPP] = front_reg[rd_idx];
  end

endmodule

// File: rtl/led_matrix_pwm.sv
// Multiplexed LED-matrix driver with per-pixel PWM. Scans one source column at a
// time: BLANK dark clocks, then (2^BPP-1) PWM ticks of TICK_DIV clocks each.
// Outputs are registered from the current scan position, so they trail the
// position registers by one clock; this makes the first frame_start appear one
// clock after reset release. Build option LED_MATRIX_DOUBLE_BUF_EN selects the
// double-buffered framebuffer with commit/swap.
module led_matrix_pwm
  import led_matrix_pkg::*;
#(
  parameter int ROWS     = DEF_ROWS,
  parameter int COLS     = DEF_COLS,
  parameter int BPP      = DEF_BPP,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int BLANK    = DEF_BLANK
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          wr_en,
  input  logic [$clog2(ROWS*COLS)-1:0]  wr_addr,
  input  logic [BPP-1:0]                wr_data,
  input  logic                          commit,
  output logic [ROWS-1:0]               aled,
  output logic [COLS-1:0]               kled_tri,
  output logic                          frame_start,
  output logic                          swap_pending
);

  localparam int AW    = $clog2(ROWS * COLS);
  localparam int COLW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int NTICK = (1 << BPP) - 1;
  localparam int DIVW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BLKW  = (BLANK > 1) ? $clog2(BLANK) : 1;

  scan_state_e         state_reg, state_next;
  logic [COLW-1:0]     col_reg, col_next;
  logic [BLKW-1:0]     blank_reg, blank_next;
  logic [DIVW-1:0]     div_reg, div_next;
  logic [BPP-1:0]      tick_reg, tick_next;

  logic [ROWS-1:0]     aled_reg, aled_next;
  logic [COLS-1:0]     kled_reg, kled_next;
  logic                fs_reg, fs_next;

  logic [ROWS*BPP-1:0] col_pix;
  logic                swap_go;

  // The first BLANK clock of column 0 is the frame boundary and the swap point.
  assign swap_go = (state_reg == ST_BLANK) && (col_reg == '0) && (blank_reg == '0);

  led_frame_buf #(
    .ROWS (ROWS),
    .COLS (COLS),
    .BPP  (BPP),
    .AW   (AW),
    .COLW (COLW)
  ) u_frame_buf (
    .clk          (clk),
    .resetn       (resetn),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .commit       (commit),
    .swap         (swap_go),
    .rd_col       (col_reg),
    .rd_pix       (col_pix),
    .swap_pending (swap_pending)
  );

  // Scan position and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= ST_BLANK;
      col_reg   <= '0;
      blank_reg <= '0;
      div_reg   <= '0;
      tick_reg  <= '0;
      aled_reg  <= '1;
      kled_reg  <= '0;
      fs_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      col_reg   <= col_next;
      blank_reg <= blank_next;
      div_reg   <= div_next;
      tick_reg  <= tick_next;
      aled_reg  <= aled_next;
      kled_reg  <= kled_next;
      fs_reg    <= fs_next;
    end
  end

  // Next scan position and the outputs that belong to the current position.
  always_comb begin
    state_next = state_reg;
    col_next   = col_reg;
    blank_next = blank_reg;
    div_next   = div_reg;
    tick_next  = tick_reg;
    aled_next  = aled_reg;
    kled_next  = '0;
    fs_next    = 1'b0;

    case (state_reg)
      ST_BLANK: begin
        aled_next = '1;
        fs_next   = (col_reg == '0) && (blank_reg == '0);
        if (blank_reg == BLKW'(BLANK - 1)) begin
          state_next = ST_LIT;
          blank_next = '0;
          div_next   = '0;
          tick_next  = '0;
        end else begin
          blank_next = blank_reg + 1'b1;
        end
      end
      ST_LIT: begin
        kled_next = COLS'(1) << col_reg;
        // Sinks are re-evaluated only at the first clock of each tick.
        if (div_reg == '0) begin
          for (int r = 0; r < ROWS; r++) begin
            aled_next[r] = ~(col_pix[r*BPP +: BPP] > tick_reg);
          end
        end
        if (div_reg == DIVW'(TICK_DIV - 1)) begin
          div_next = '0;
          if (tick_reg == BPP'(NTICK - 1)) begin
            state_next = ST_BLANK;
            tick_next  = '0;
            col_next   = (col_reg == COLW'(COLS - 1)) ? '0 : col_reg + 1'b1;
          end else begin
            tick_next = tick_reg + 1'b1;
          end
        end else begin
          div_next = div_reg + 1'b1;
        end
      end
      default: begin
        state_next = ST_BLANK;
      end
    endcase
  end

  assign aled        = aled_reg;
  assign kled_tri    = kled_reg;
  assign frame_start = fs_reg;

endmodule

// File: tb/tb_led_matrix_pwm.sv
// Bench for led_matrix_pwm: a frame-position model predicts every output each
// cycle, and directed literal checks pin the model at known scan positions.
module tb_led_matrix_pwm;

  localparam int ROWS     = 4;
  localparam int COLS     = 4;
  localparam int BPP      = 4;
  localparam int TICK_DIV = 32;
  localparam int BLANK    = 16;
  localparam int NPIX     = ROWS * COLS;
  localparam int NLVL     = (1 << BPP) - 1;
  localparam int PHASE    = BLANK + NLVL * TICK_DIV;
  localparam int FRAME    = COLS * PHASE;

  logic           clk = 1'b0;
  logic           resetn = 1'b1;
  logic           wr_en = 1'b0;
  logic [3:0]     wr_addr = '0;
  logic [BPP-1:0] wr_data = '0;
  logic           commit = 1'b0;
  logic [3:0]     aled;
  logic [3:0]     kled_tri;
  logic           frame_start;
  logic           swap_pending;

  int total = 0;
  int bad = 0;
  int cur_pos = 0;

  // model state
  int   back_m  [NPIX];
  int   front_m [NPIX];
  bit   pend_m = 1'b0;
  int   n_m = 0;
  bit   model_on = 1'b0;
  logic [3:0] exp_aled = 4'hF;
  logic [3:0] exp_kled = 4'h0;
  logic       exp_fs = 1'b0;
  logic       exp_pend = 1'b0;

  always #5 clk = ~clk;

  led_matrix_pwm dut (
    .clk          (clk),
    .resetn       (resetn),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .commit       (commit),
    .aled         (aled),
    .kled_tri     (kled_tri),
    .frame_start  (frame_start),
    .swap_pending (swap_pending)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Model: each rising edge produces the outputs of scan position n (counted
  // from reset release), using the pixels as they stood before that edge.
  initial begin : model
    int pos, col, off, lt;
    forever begin
      @(posedge clk);
      if (!resetn) begin
        for (int i = 0; i < NPIX; i++) begin
          back_m[i]  = 0;
          front_m[i] = 0;
        end
        pend_m = 1'b0; n_m = 0; model_on = 1'b1;
        exp_aled = 4'hF; exp_kled = 4'h0; exp_fs = 1'b0; exp_pend = 1'b0;
      end else if (model_on) begin
        pos = n_m % FRAME;
        n_m++;
        col = pos / PHASE;
        off = pos % PHASE;
        exp_fs = (pos == 0);
        if (off < BLANK) begin
          exp_kled = 4'h0;
          exp_aled = 4'hF;
        end else begin
          lt = off - BLANK;
          exp_kled = 4'(1 << col);
          if (lt % TICK_DIV == 0) begin
            for (int r = 0; r < ROWS; r++) begin
              exp_aled[r] = !(front_m[col * ROWS + r] > lt / TICK_DIV);
            end
          end
        end
`ifdef LED_MATRIX_DOUBLE_BUF_EN
        if (wr_en) back_m[wr_addr] = int'(wr_data);
        if (pos == 0 && pend_m) begin
          front_m = back_m;
          pend_m  = commit;
        end else begin
          pend_m = pend_m | commit;
        end
`else
        if (wr_en) front_m[wr_addr] = int'(wr_data);
        pend_m = 1'b0;
`endif
        exp_pend = pend_m;
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (model_on) begin
        check("aled", 32'(aled), 32'(exp_aled));
        check("kled_tri", 32'(kled_tri), 32'(exp_kled));
        check("frame_start", 32'(frame_start), 32'(exp_fs));
        check("swap_pending", 32'(swap_pending), 32'(exp_pend));
        check("kled_onehot0", 32'($onehot0(kled_tri)), 32'd1);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    cur_pos = (cur_pos + 1) % FRAME;
  endtask

  task automatic goto(input int p);
    int d;
    d = (p - cur_pos + FRAME) % FRAME;
    repeat (d) step();
  endtask

  task automatic write_px(input int a, input int d);
    wr_en = 1'b1; wr_addr = 4'(a); wr_data = 4'(d);
    step();
    wr_en = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    step();
    commit = 1'b0;
  endtask

  task automatic expect_px(input string name, input int p, input logic [3:0] a, input logic [3:0] k);
    goto(p);
    check({name, "_aled"}, 32'(aled), 32'(a));
    check({name, "_kled"}, 32'(kled_tri), 32'(k));
  endtask

  logic exp_dbl;

  initial begin : driver
    int cyc;
`ifdef LED_MATRIX_DOUBLE_BUF_EN
    exp_dbl = 1'b1;
`else
    exp_dbl = 1'b0;
`endif
    #2 resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_aled", 32'(aled), 32'hF);
    check("rst_kled", 32'(kled_tri), 32'h0);
    check("rst_fs", 32'(frame_start), 32'h0);
    check("rst_pend", 32'(swap_pending), 32'h0);
    resetn = 1'b1;
    @(negedge clk);
    cur_pos = 0;
    check("first_fs", 32'(frame_start), 32'h1);

    // p5 (c1,r1)=15, p0=8, then commit
    write_px(5, 15);
    write_px(0, 8);
    pulse_commit();
    check("pend_set", 32'(swap_pending), 32'(exp_dbl));

    cyc = cur_pos;
    while (!frame_start && cyc < FRAME + 20) begin
      @(negedge clk);
      cyc++;
    end
    check("frame_period", 32'(cyc), 32'(FRAME));
    cur_pos = 0;

    // frame 2 literal expectations
    expect_px("c0_t0", 16, 4'b1110, 4'b0001);
    expect_px("c0_t7", 271, 4'b1110, 4'b0001);
    expect_px("c0_t8", 272, 4'b1111, 4'b0001);
    expect_px("c1_first", 512, 4'b1101, 4'b0010);
    expect_px("c1_last", 991, 4'b1101, 4'b0010);
    expect_px("c2_blank", 992, 4'b1111, 4'b0000);
    expect_px("c2_lit", 1108, 4'b1111, 4'b0100);

    // write without commit
    goto(1200);
    write_px(5, 0);
    expect_px("nocommit", FRAME + 600 - FRAME, exp_dbl ? 4'b1101 : 4'b1111, 4'b0010);
    pulse_commit();
    // commit on the swap edge: swap happens, request stays pending
    goto(FRAME - 1);
    pulse_commit();
    check("swap_fs", 32'(frame_start), 32'h1);
    check("swap_keep_pend", 32'(swap_pending), 32'(exp_dbl));
    expect_px("after_swap", 600, 4'b1111, 4'b0010);
    goto(1000);
    check("pend_hold", 32'(swap_pending), 32'(exp_dbl));
    goto(0);
    check("pend_clear", 32'(swap_pending), 32'h0);

    // randomized traffic for two frames
    for (int i = 0; i < 2 * FRAME; i++) begin
      wr_en   = ($urandom_range(3) == 0);
      wr_addr = 4'($urandom_range(15));
      wr_data = 4'($urandom_range(15));
      commit  = ($urandom_range(299) == 0);
      step();
    end
    wr_en = 1'b0;
    commit = 1'b0;

    // reset in the middle of column 1 LIT
    goto(700);
    #2 resetn = 1'b0;
    #1;
    check("midrst_aled", 32'(aled), 32'hF);
    check("midrst_kled", 32'(kled_tri), 32'h0);
    check("midrst_fs", 32'(frame_start), 32'h0);
    check("midrst_pend", 32'(swap_pending), 32'h0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    cur_pos = 0;
    check("rerst_fs", 32'(frame_start), 32'h1);
    expect_px("cleared_c0", 100, 4'b1111, 4'b0001);
    expect_px("cleared_c1", 612, 4'b1111, 4'b0010);
    goto(FRAME - 1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
